uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Serial 8N1-style transmitter that drains a FIFO through the FIFO's pop-side interface (data, empty flag, pop strobe).
- It takes one word whenever the FIFO is non-empty and transmitting is enabled, then shifts the word out LSB-first with start and stop bits at a fixed clock-per-bit rate.
- It sits directly on the read port of the team's fifo block, paired with a CPU-side writer on the push side.

Parameters:
- CLKS_PER_BIT, 868, clk_i cycles per serial bit; legal range is 2 or more (868 gives 115200 baud at 100 MHz).
- DBITS, 8, data bits per frame; equal to the FIFO DWIDTH.

Ports:
- clk_i  input  1  system clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- tx_en  input  1  when high, new frames may start; when low, the current frame completes and no new pop occurs.
- fifo_empty  input  1  FIFO empty flag; fifo_data is valid when this is low.
- fifo_data  input  DBITS  FIFO head word (combinational from the FIFO, valid while not empty).
- fifo_pop  output  1  one-cycle strobe that consumes the FIFO head.
- tx  output  1  serial line, idle high.
- busy  output  1  high whenever a frame is in progress (state is not IDLE).

Behaviour:
- Reset (async, rst_i=1):
  - State goes to IDLE immediately; tx=1, busy=0, fifo_pop=0.
  - Bit timer, bit index and shift register clear to 0.
  - Reset mid-frame aborts the frame at once: tx returns high without waiting for a clock.
- Registers: state, shift register [DBITS-1:0], bit timer ($clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1), bit index ($clog2(DBITS) bits), and registered tx.
- fifo_pop is combinational from state and inputs: fifo_pop = take, where take = tx_en && !fifo_empty && (state==IDLE || (state==STOP && timer==CLKS_PER_BIT-1)).
- On the edge where take is high:
  - fifo_data is captured into the shift register.
  - State becomes START, timer is set to 0 and tx is set to 0.
  - The FIFO advances its read pointer on the same edge, so exactly one word is consumed per frame.
  - The pop lasts one cycle.
- States:
  - IDLE: tx=1. If take, go to START as above; otherwise stay in IDLE.
  - START: tx=0 for CLKS_PER_BIT cycles. At timer==CLKS_PER_BIT-1: timer goes to 0, bit index to 0, tx to shift[0], and state to DATA.
  - DATA: tx holds the current bit for CLKS_PER_BIT cycles. At the end of a bit, the shift register moves right by one and tx takes the next bit. After bit index DBITS-1 completes, tx=1 and state goes to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last stop cycle, if take, go straight to START with no idle gap; otherwise go to IDLE.
- Timer behaviour: it increments every cycle outside IDLE and wraps to 0 at CLKS_PER_BIT-1.
- Frame length: exactly (DBITS+2)*CLKS_PER_BIT cycles. Back-to-back frames from a continuously non-empty FIFO produce no gaps.
- Bit order: LSB first.
- tx_en:
  - Sampled only at take opportunities.
  - Deasserting it mid-frame has no effect on the current frame.
  - It holds the FIFO contents untouched.
- fifo_empty rising mid-frame has no effect; the frame uses the captured copy.
- fifo_data changing after capture has no effect.
- No pop is ever issued when fifo_empty=1, so there is no underflow.
- busy=1 from the edge after take until the edge that returns the state to IDLE.

Test Plan:
- Single word: CLKS_PER_BIT=4, FIFO holds 0xA5, tx_en=1 -> fifo_pop high for exactly 1 cycle. tx then reads 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles. busy falls after 40 cycles and tx stays 1.
- Back-to-back: FIFO holds 0x00 then 0xFF -> second pop coincides with the last stop-bit cycle of frame 1. The second start bit follows with no extra idle cycle; total time is 80 cycles; exactly 2 pops.
- Empty / disabled:
  - fifo_empty=1 for 100 cycles -> fifo_pop never high, tx=1, busy=0.
  - Then tx_en=0 with the FIFO non-empty -> still no pop.
  - Raising tx_en -> pop on the same cycle.
- tx_en drop mid-frame: drop tx_en during DATA with 2 words queued -> frame 1 completes intact, state goes to IDLE, and no second pop until tx_en returns high.
- Reset mid-frame: assert rst_i during DATA bit 3 -> tx=1 and busy=0 immediately without a clock edge. After release with the FIFO non-empty, a fresh frame starts from its start bit and a new pop is issued.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1-style serial transmitter that drains a FIFO read port.
// One word is popped per frame, then shifted out LSB-first between a start
// bit (0) and a stop bit (1), each bit lasting CLKS_PER_BIT clocks.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DBITS        = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tx_en,
    input  logic             fifo_empty,
    input  logic [DBITS-1:0] fifo_data,
    output logic             fifo_pop,
    output logic             tx,
    output logic             busy
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IW = (DBITS > 1) ? $clog2(DBITS) : 1;

    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DBITS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [DBITS-1:0] shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q;
    logic             bit_end_c;
    logic             take_c;

    // Pop is combinational so the FIFO advances on the same edge that captures its head.
    assign fifo_pop = take_c;
    assign tx       = tx_q;
    assign busy     = busy_q;

    // Next-state, timer, shifter and line value.
    always_comb begin
        bit_end_c = (timer_q == T_LAST);
        take_c    = !rst_i && tx_en && !fifo_empty &&
                    ((state_q == IDLE) || ((state_q == STOP) && bit_end_c));

        state_d = state_q;
        timer_d = (state_q == IDLE || bit_end_c) ? '0 : timer_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
            end
            START: begin
                if (bit_end_c) begin
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    if (idx_q == I_LAST) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    tx_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase

        // A take (from IDLE or the last stop cycle) always launches a new frame.
        if (take_c) begin
            shift_d = fifo_data;
            state_d = START;
            timer_d = '0;
            tx_d    = 1'b0;
        end
    end

    // State and datapath registers; reset forces the line idle at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != IDLE);
        end
    end

endmodule
